// File: rtl/oled_pixel_streamer.sv
// SSD1331 PmodOLED SPI driver: power-up and init command sequence, then an endless
// RGB565 pixel stream that prefetches pixel_data one pixel ahead of the shifter.
module oled_pixel_streamer #(
  parameter int CLK_DIV         = 1,
  parameter int PIXEL_LATENCY   = 2,
  parameter int POWERUP_CYCLES  = 20000,
  parameter int RESET_CYCLES    = 20,
  parameter int VCC_WAIT_CYCLES = 25000,
  parameter int FRAME_PIXELS    = 6144
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);
  localparam int ROM_LEN = 43;
  localparam int CMAX0   = (POWERUP_CYCLES > VCC_WAIT_CYCLES) ? POWERUP_CYCLES : VCC_WAIT_CYCLES;
  localparam int CMAX    = (CMAX0 > RESET_CYCLES) ? CMAX0 : RESET_CYCLES;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW      = $clog2(32 * CLK_DIV + 1);

  typedef enum logic [2:0] {PWR_OFF, RST_LO, RST_HI, INIT, VCC_ON, DISP_ON, STREAM} state_t;

  function automatic logic [7:0] rom_byte(input logic [5:0] i);
    case (i)
      6'd0:  rom_byte = 8'hAE; 6'd1:  rom_byte = 8'hA0; 6'd2:  rom_byte = 8'h72;
      6'd3:  rom_byte = 8'hA1; 6'd4:  rom_byte = 8'h00; 6'd5:  rom_byte = 8'hA2;
      6'd6:  rom_byte = 8'h00; 6'd7:  rom_byte = 8'hA4; 6'd8:  rom_byte = 8'hA8;
      6'd9:  rom_byte = 8'h3F; 6'd10: rom_byte = 8'hAD; 6'd11: rom_byte = 8'h8E;
      6'd12: rom_byte = 8'hB0; 6'd13: rom_byte = 8'h0B; 6'd14: rom_byte = 8'hB1;
      6'd15: rom_byte = 8'h31; 6'd16: rom_byte = 8'hB3; 6'd17: rom_byte = 8'hF0;
      6'd18: rom_byte = 8'h8A; 6'd19: rom_byte = 8'h64; 6'd20: rom_byte = 8'h8B;
      6'd21: rom_byte = 8'h78; 6'd22: rom_byte = 8'h8C; 6'd23: rom_byte = 8'h64;
      6'd24: rom_byte = 8'hBB; 6'd25: rom_byte = 8'h3A; 6'd26: rom_byte = 8'hBE;
      6'd27: rom_byte = 8'h3E; 6'd28: rom_byte = 8'h87; 6'd29: rom_byte = 8'h06;
      6'd30: rom_byte = 8'h81; 6'd31: rom_byte = 8'h91; 6'd32: rom_byte = 8'h82;
      6'd33: rom_byte = 8'h50; 6'd34: rom_byte = 8'h83; 6'd35: rom_byte = 8'h7D;
      6'd36: rom_byte = 8'h2E; 6'd37: rom_byte = 8'h15; 6'd38: rom_byte = 8'h00;
      6'd39: rom_byte = 8'h5F; 6'd40: rom_byte = 8'h75; 6'd41: rom_byte = 8'h00;
      6'd42: rom_byte = 8'h3F;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      rom_ptr_q, rom_ptr_d;
  logic            busy_q, busy_d, hi_q, hi_d, run_q, run_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      bits_left_q, bits_left_d;
  logic [15:0]     sh_q, sh_d, hold_q, hold_d;
  logic [PW-1:0]   pix_cyc_q, pix_cyc_d;
  logic [12:0]     idx_q, idx_d, idx_next;
  logic            samp_q, samp_d, fb_q, fb_d, send_q, send_d;
  logic            cs_q, cs_d, sclk_q, sclk_d, sdin_q, sdin_d, dcn_q, dcn_d;
  logic            resn_q, resn_d, vcc_q, vcc_d, pmod_q, pmod_d;
  logic            bit_end, unit_done, wrap, load_en;
  logic [15:0]     load_word;
  logic [3:0]      load_bits;

  assign bit_end   = busy_q && hi_q && (div_q == DW'(CLK_DIV - 1));
  assign unit_done = bit_end && (bits_left_q == 4'd0);
  assign wrap      = (idx_q == 13'(FRAME_PIXELS - 1));
  assign idx_next  = wrap ? 13'd0 : idx_q + 13'd1;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  rom_ptr_d = rom_ptr_q;
    busy_d = busy_q;  hi_d = hi_q;  run_d = run_q;  div_d = div_q;
    bits_left_d = bits_left_q;  sh_d = sh_q;  hold_d = hold_q;  pix_cyc_d = pix_cyc_q;
    idx_d = idx_q;  samp_d = 1'b0;  fb_d = 1'b0;  send_d = send_q;
    cs_d = cs_q;  sclk_d = sclk_q;  sdin_d = sdin_q;  dcn_d = dcn_q;
    resn_d = resn_q;  vcc_d = vcc_q;  pmod_d = pmod_q;
    load_en = 1'b0;  load_word = 16'h0000;  load_bits = 4'd7;

    // Bit engine: low phase then high phase of CLK_DIV cycles each; sclk parks high when idle.
    if (busy_q) begin
      if (div_q == DW'(CLK_DIV - 1)) begin
        div_d = '0;
        if (!hi_q) begin
          hi_d = 1'b1;  sclk_d = 1'b1;
        end else if (bits_left_q != 4'd0) begin
          hi_d = 1'b0;  sclk_d = 1'b0;  sh_d = sh_q << 1;  sdin_d = sh_q[14];
          bits_left_d = bits_left_q - 4'd1;
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      PWR_OFF: begin
        pmod_d = 1'b1;
        if (cnt_q == CW'(POWERUP_CYCLES)) begin
          state_d = RST_LO;  resn_d = 1'b0;  cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      RST_LO: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = RST_HI;  resn_d = 1'b1;  cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      RST_HI: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = INIT;  cs_d = 1'b0;  dcn_d = 1'b0;  rom_ptr_d = '0;
          load_en = 1'b1;  load_word = {rom_byte(6'd0), 8'h00};
        end else cnt_d = cnt_q + 1'b1;
      end
      INIT: begin
        if (unit_done) begin
          if (rom_ptr_q == 6'(ROM_LEN - 1)) begin
            state_d = VCC_ON;  cs_d = 1'b1;  vcc_d = 1'b1;  cnt_d = '0;
          end else begin
            rom_ptr_d = rom_ptr_q + 6'd1;
            load_en = 1'b1;  load_word = {rom_byte(rom_ptr_q + 6'd1), 8'h00};
          end
        end
      end
      VCC_ON: begin
        if (cnt_q == CW'(VCC_WAIT_CYCLES - 1)) begin
          state_d = DISP_ON;  cs_d = 1'b0;
          load_en = 1'b1;  load_word = 16'hAF00;
        end else cnt_d = cnt_q + 1'b1;
      end
      DISP_ON: begin
        if (unit_done) begin
          state_d = STREAM;  dcn_d = 1'b1;  send_d = 1'b1;
          idx_d = 13'd0;  fb_d = 1'b1;  pix_cyc_d = '0;  run_d = 1'b0;
        end
      end
      default: begin
        pix_cyc_d = pix_cyc_q + 1'b1;
        if (pix_cyc_q == PW'(PIXEL_LATENCY - 1)) begin
          samp_d = 1'b1;  hold_d = pixel_data;
        end
        // Pixel start: shift the held word and request the next pixel in the same cycle.
        if ((!run_q && pix_cyc_q == PW'(PIXEL_LATENCY)) || (run_q && unit_done)) begin
          load_en = 1'b1;  load_word = hold_q;  load_bits = 4'd15;
          run_d = 1'b1;  pix_cyc_d = '0;  idx_d = idx_next;  fb_d = wrap;
        end
      end
    endcase

    if (load_en) begin
      busy_d = 1'b1;  hi_d = 1'b0;  div_d = '0;  sclk_d = 1'b0;
      sh_d = load_word;  sdin_d = load_word[15];  bits_left_d = load_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= PWR_OFF;  cnt_q <= '0;  rom_ptr_q <= '0;
      busy_q <= 1'b0;  hi_q <= 1'b0;  run_q <= 1'b0;  div_q <= '0;
      bits_left_q <= '0;  sh_q <= '0;  hold_q <= '0;  pix_cyc_q <= '0;
      idx_q <= '0;  samp_q <= 1'b0;  fb_q <= 1'b0;  send_q <= 1'b0;
      cs_q <= 1'b1;  sclk_q <= 1'b1;  sdin_q <= 1'b0;  dcn_q <= 1'b0;
      resn_q <= 1'b1;  vcc_q <= 1'b0;  pmod_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  rom_ptr_q <= rom_ptr_d;
      busy_q <= busy_d;  hi_q <= hi_d;  run_q <= run_d;  div_q <= div_d;
      bits_left_q <= bits_left_d;  sh_q <= sh_d;  hold_q <= hold_d;  pix_cyc_q <= pix_cyc_d;
      idx_q <= idx_d;  samp_q <= samp_d;  fb_q <= fb_d;  send_q <= send_d;
      cs_q <= cs_d;  sclk_q <= sclk_d;  sdin_q <= sdin_d;  dcn_q <= dcn_d;
      resn_q <= resn_d;  vcc_q <= vcc_d;  pmod_q <= pmod_d;
    end
  end

  assign pixel_index    = idx_q;
  assign sample_pixel   = samp_q;
  assign frame_begin    = fb_q;
  assign sending_pixels = send_q;
  assign cs             = cs_q;
  assign sclk           = sclk_q;
  assign sdin           = sdin_q;
  assign d_cn           = dcn_q;
  assign resn           = resn_q;
  assign vccen          = vcc_q;
  assign pmoden         = pmod_q;
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: two instances (fast divider / slow divider with a short frame),
// SPI decoded from sclk rising edges and compared to the command list and a per-pixel colour rule.
module tb_oled_pixel_streamer;
  localparam int P = 10, R = 4, V = 8, NPIX1 = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn0 = 1'b0, rn1 = 1'b0;
  logic [15:0] pd0 = 16'h0, pd1 = 16'h0;
  logic [12:0] idx0, idx1;
  logic samp0, fb0, send0, cs0, sclk0, sdin0, dcn0, resn0, vcc0, pmod0;
  logic samp1, fb1, send1, cs1, sclk1, sdin1, dcn1, resn1, vcc1, pmod1;

  oled_pixel_streamer #(.CLK_DIV(1), .PIXEL_LATENCY(2), .POWERUP_CYCLES(P),
    .RESET_CYCLES(R), .VCC_WAIT_CYCLES(V)) dut0 (
    .clock(clk), .resetn(rn0), .pixel_data(pd0), .pixel_index(idx0), .sample_pixel(samp0),
    .frame_begin(fb0), .sending_pixels(send0), .cs(cs0), .sclk(sclk0), .sdin(sdin0),
    .d_cn(dcn0), .resn(resn0), .vccen(vcc0), .pmoden(pmod0));

  oled_pixel_streamer #(.CLK_DIV(3), .PIXEL_LATENCY(5), .POWERUP_CYCLES(P),
    .RESET_CYCLES(R), .VCC_WAIT_CYCLES(V), .FRAME_PIXELS(NPIX1)) dut1 (
    .clock(clk), .resetn(rn1), .pixel_data(pd1), .pixel_index(idx1), .sample_pixel(samp1),
    .frame_begin(fb1), .sending_pixels(send1), .cs(cs1), .sclk(sclk1), .sdin(sdin1),
    .d_cn(dcn1), .resn(resn1), .vccen(vcc1), .pmoden(pmod1));

  int sel = 0, cd = 1, lat = 2, npix = 6144;
  logic [15:0] key = 16'h0000;
  logic [12:0] m_idx;
  logic m_samp, m_fb, m_send, m_cs, m_sclk, m_sdin, m_dcn, m_resn, m_vcc, m_pmod;
  assign m_idx  = sel != 0 ? idx1  : idx0;
  assign m_samp = sel != 0 ? samp1 : samp0;
  assign m_fb   = sel != 0 ? fb1   : fb0;
  assign m_send = sel != 0 ? send1 : send0;
  assign m_cs   = sel != 0 ? cs1   : cs0;
  assign m_sclk = sel != 0 ? sclk1 : sclk0;
  assign m_sdin = sel != 0 ? sdin1 : sdin0;
  assign m_dcn  = sel != 0 ? dcn1  : dcn0;
  assign m_resn = sel != 0 ? resn1 : resn0;
  assign m_vcc  = sel != 0 ? vcc1  : vcc0;
  assign m_pmod = sel != 0 ? pmod1 : pmod0;

  logic [7:0] rom_exp [43] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
    8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'h81, 8'h91,
    8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0]  cmd [$];
  logic [15:0] words [$];
  int fb_cyc [$], samp_cyc [$];
  logic [7:0]  cacc;
  logic [15:0] pacc;
  int cbits, pbits, gap_bad, phase_bad, samp_bad, samp_cnt, last_rise, low_run, since;
  logic prev_sclk;
  logic [12:0] last_idx;

  function automatic logic [15:0] colour(input logic [12:0] i);
    return {3'b000, i} ^ key;
  endfunction

  task automatic clear_mon();
    cmd.delete(); words.delete(); fb_cyc.delete(); samp_cyc.delete();
    cacc = '0; pacc = '0; cbits = 0; pbits = 0; gap_bad = 0; phase_bad = 0;
    samp_bad = 0; samp_cnt = 0; last_rise = -1; low_run = 0; since = 999;
    prev_sclk = 1'b1; last_idx = '0;
  endtask

  // One clock: observe at the falling edge, decode SPI, then drive the upstream pixel_data,
  // which is only the true colour in the single cycle the streamer is allowed to sample it.
  task automatic tick();
    logic [15:0] v;
    @(negedge clk);
    cyc++;
    if (m_fb || m_idx != last_idx) since = 0; else if (since < 999) since++;
    last_idx = m_idx;
    if (m_samp) begin
      samp_cnt++; samp_cyc.push_back(cyc);
      if (since != lat || !m_send) samp_bad++;
    end
    if (m_fb) fb_cyc.push_back(cyc);
    if (!m_cs && !prev_sclk && m_sclk) begin
      if (low_run != cd) phase_bad++;
      if (m_dcn) begin
        if (last_rise >= 0 && cyc - last_rise != 2 * cd) gap_bad++;
        last_rise = cyc;
        pacc = {pacc[14:0], m_sdin}; pbits++;
        if (pbits == 16) begin words.push_back(pacc); pbits = 0; end
      end else begin
        cacc = {cacc[6:0], m_sdin}; cbits++;
        if (cbits == 8) begin cmd.push_back(cacc); cbits = 0; end
      end
    end
    if (!m_dcn) last_rise = -1;
    low_run = m_sclk ? 0 : low_run + 1;
    prev_sclk = m_sclk;
    v = (since == lat - 1) ? colour(m_idx) : 16'($urandom);
    if (sel != 0) pd1 = v; else pd0 = v;
  endtask

  task automatic test_reset();
    if (sel != 0) rn1 = 1'b0; else rn0 = 1'b0;
    tick();
    checks++;
    if ({m_pmod, m_vcc, m_resn, m_cs, m_sclk, m_sdin, m_dcn, m_samp, m_fb, m_send} !== 10'b0011100000) begin
      errors++;
      $display("FAIL reset_outputs dut%0d got %b want 0011100000", sel,
        {m_pmod, m_vcc, m_resn, m_cs, m_sclk, m_sdin, m_dcn, m_samp, m_fb, m_send});
    end
    checks++;
    if (m_idx !== 13'd0) begin errors++; $display("FAIL reset_index dut%0d got %0d want 0", sel, m_idx); end
    repeat (3) tick();
    clear_mon();
  endtask

  task automatic test_powerup();
    int pm = -1, rf = -1, lo = 0, csf = -1, vseen = 0;
    if (sel != 0) rn1 = 1'b1; else rn0 = 1'b1;
    for (int k = 1; k <= P + 2 * R + 2; k++) begin
      tick();
      if (m_pmod && pm < 0) pm = k;
      if (!m_resn && rf < 0) rf = k;
      if (!m_resn) lo++;
      if (!m_cs && csf < 0) csf = k;
      if (m_vcc) vseen++;
    end
    checks++; if (pm != 1) begin errors++; $display("FAIL pmoden_rise got %0d want 1", pm); end
    checks++; if (rf != P + 1) begin errors++; $display("FAIL resn_fall got %0d want %0d", rf, P + 1); end
    checks++; if (lo != R) begin errors++; $display("FAIL resn_low_len got %0d want %0d", lo, R); end
    checks++; if (csf != P + 1 + 2 * R) begin errors++; $display("FAIL cs_fall got %0d want %0d", csf, P + 1 + 2 * R); end
    checks++; if (vseen != 0) begin errors++; $display("FAIL vccen_early got %0d want 0", vseen); end
  endtask

  task automatic test_init();
    int vcc_at = -1, cs_hi = 0;
    int lim = 50 * 16 * cd + V + 200;
    for (int t = 0; t < lim && cmd.size() < 44; t++) begin
      tick();
      if (m_vcc && vcc_at < 0) vcc_at = cmd.size();
      if (m_vcc && m_cs) cs_hi++;
    end
    checks++;
    if (cmd.size() < 44) begin
      errors++; $display("FAIL init_timeout got %0d bytes want 44", cmd.size());
    end else begin
      for (int i = 0; i < 43; i++) begin
        checks++;
        if (cmd[i] !== rom_exp[i]) begin errors++; $display("FAIL init_byte[%0d] got %h want %h", i, cmd[i], rom_exp[i]); end
      end
      checks++; if (cmd[43] !== 8'hAF) begin errors++; $display("FAIL disp_on got %h want af", cmd[43]); end
    end
    checks++; if (vcc_at != 43) begin errors++; $display("FAIL vccen_after_bytes got %0d want 43", vcc_at); end
    checks++; if (cs_hi != V) begin errors++; $display("FAIL vcc_wait_cs_high got %0d want %0d", cs_hi, V); end
    checks++; if (phase_bad != 0) begin errors++; $display("FAIL cmd_sclk_phase got %0d bad want 0", phase_bad); end
  endtask

  task automatic test_stream(input int n);
    int ent = -1, s0 = -1, fall0 = -1;
    int lim = n * 32 * cd + 64 * cd + 100;
    for (int t = 0; t < lim && words.size() < n; t++) begin
      tick();
      if (m_send && ent < 0) ent = cyc;
      if (ent >= 0 && m_samp && s0 < 0) s0 = cyc;
      if (ent >= 0 && !m_sclk && fall0 < 0) fall0 = cyc;
    end
    checks++;
    if (words.size() < n) begin
      errors++; $display("FAIL stream_timeout got %0d words want %0d", words.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (words[k] !== colour(13'(k % npix))) begin
          errors++; $display("FAIL pixel_word[%0d] got %h want %h", k, words[k], colour(13'(k % npix)));
        end
      end
    end
    checks++; if (s0 - ent != lat) begin errors++; $display("FAIL first_sample_delay got %0d want %0d", s0 - ent, lat); end
    checks++; if (fall0 - ent != lat + 1) begin errors++; $display("FAIL first_shift_delay got %0d want %0d", fall0 - ent, lat + 1); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL stream_sclk_gaps got %0d want 0", gap_bad); end
    checks++; if (phase_bad != 0) begin errors++; $display("FAIL stream_sclk_phase got %0d want 0", phase_bad); end
    checks++; if (samp_bad != 0) begin errors++; $display("FAIL sample_timing got %0d bad want 0", samp_bad); end
    checks++; if (samp_cnt != n + 1) begin errors++; $display("FAIL sample_count got %0d want %0d", samp_cnt, n + 1); end
    checks++; if ({m_dcn, m_send, m_cs} !== 3'b110) begin errors++; $display("FAIL stream_ctrl got %b want 110", {m_dcn, m_send, m_cs}); end
  endtask

  task automatic test_frame_wrap();
    int per = npix * 32 * cd, in_frame = 0;
    checks++;
    if (fb_cyc.size() != 3) begin
      errors++; $display("FAIL frame_begin_count got %0d want 3", fb_cyc.size());
    end else begin
      checks++;
      if (fb_cyc[1] - fb_cyc[0] != lat + 1 + (npix - 1) * 32 * cd) begin
        errors++; $display("FAIL first_wrap_time got %0d want %0d", fb_cyc[1] - fb_cyc[0], lat + 1 + (npix - 1) * 32 * cd);
      end
      checks++;
      if (fb_cyc[2] - fb_cyc[1] != per) begin
        errors++; $display("FAIL frame_period got %0d want %0d", fb_cyc[2] - fb_cyc[1], per);
      end
      foreach (samp_cyc[i]) if (samp_cyc[i] >= fb_cyc[1] && samp_cyc[i] < fb_cyc[2]) in_frame++;
      checks++;
      if (in_frame != npix) begin errors++; $display("FAIL samples_per_frame got %0d want %0d", in_frame, npix); end
    end
    checks++;
    if (words.size() > npix && words[npix] !== colour(13'd0)) begin
      errors++; $display("FAIL wrap_word got %h want %h", words[npix], colour(13'd0));
    end
  endtask

  task automatic test_midstream_reset();
    for (int t = 0; t < 400 && !(pbits == 5 && !m_sclk); t++) tick();
    checks++;
    if (!(pbits == 5 && !m_sclk && m_send)) begin
      errors++; $display("FAIL midreset_setup got bits=%0d sclk=%b want bits=5 sclk=0", pbits, m_sclk);
    end
    test_reset();
    test_powerup();
    test_init();
    test_stream(6);
  endtask

  initial begin
    clear_mon();
    sel = 0; cd = 1; lat = 2; npix = 6144; key = 16'h0000;
    test_reset();
    test_powerup();
    test_init();
    test_stream(40);
    test_midstream_reset();
    rn0 = 1'b0;
    sel = 1; cd = 3; lat = 5; npix = NPIX1; key = 16'($urandom);
    test_reset();
    test_powerup();
    test_init();
    test_stream(2 * NPIX1 + 4);
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
